// File: rtl/button_gesture_if.sv
// Gesture classifier port bundle: debounced level in, event pulses out.
// master drives the button level; slave is the classifier itself.
interface button_gesture_if;
    logic clean_in;
    logic press_out;
    logic release_out;
    logic click_out;
    logic double_click_out;
    logic long_press_out;
    logic held_out;

    modport master (
        output clean_in,
        input  press_out,
        input  release_out,
        input  click_out,
        input  double_click_out,
        input  long_press_out,
        input  held_out
    );

    modport slave (
        input  clean_in,
        output press_out,
        output release_out,
        output click_out,
        output double_click_out,
        output long_press_out,
        output held_out
    );
endinterface

// File: rtl/button_gesture.sv
// Button gesture classifier: press, release, click, double click, long press.
// Windows are given in ms and turned into cycle counts at elaboration.
module button_gesture #(
    parameter int CLK_PERIOD_NS   = 10,
    parameter int LONG_PRESS_MS   = 500,
    parameter int DOUBLE_CLICK_MS = 250
) (
    input  logic              clk_in,
    input  logic              rst_in,
    button_gesture_if.slave   btn
);

    // Cycle counts, rounded up; both must be at least 2.
    localparam logic [63:0] PER      = 64'(CLK_PERIOD_NS);
    localparam logic [63:0] LONG_MAX =
        (64'(LONG_PRESS_MS) * 64'd1_000_000 + PER - 64'd1) / PER;
    localparam logic [63:0] DC_MAX   =
        (64'(DOUBLE_CLICK_MS) * 64'd1_000_000 + PER - 64'd1) / PER;
    localparam logic [63:0] CNT_MAX  =
        (LONG_MAX > DC_MAX) ? LONG_MAX : DC_MAX;
    localparam int          CW       = $clog2(CNT_MAX + 64'd1);

    localparam logic [CW-1:0] LONG_TC = CW'(LONG_MAX - 64'd1);
    localparam logic [CW-1:0] DC_TC   = CW'(DC_MAX - 64'd1);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_SECOND,
        SECOND_PRESSED
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          prev;
    logic          rise, fall;

    logic press_d, release_d, click_d, dbl_d, long_d, held_d;

    assign rise = btn.clean_in & ~prev;
    assign fall = ~btn.clean_in & prev;

    // Next state, counter and pulse decisions; a fall beats the long
    // threshold and a rise beats the double-click timeout.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        dbl_d     = 1'b0;
        long_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d   = WAIT_SECOND;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt == LONG_TC) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            WAIT_SECOND: begin
                if (rise) begin
                    state_d = SECOND_PRESSED;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else if (cnt == DC_TC) begin
                    state_d = IDLE;
                    click_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            SECOND_PRESSED: begin
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    dbl_d     = 1'b1;
                    cnt_d     = '0;
                end else if (cnt == LONG_TC) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == PRESSED) ||
                 (state_d == LONG_HELD) ||
                 (state_d == SECOND_PRESSED);
    end

    // State, counter, edge tracker and registered outputs; reset
    // resyncs prev so a button held through reset is not a press.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state                <= IDLE;
            cnt                  <= '0;
            prev                 <= btn.clean_in;
            btn.press_out        <= 1'b0;
            btn.release_out      <= 1'b0;
            btn.click_out        <= 1'b0;
            btn.double_click_out <= 1'b0;
            btn.long_press_out   <= 1'b0;
            btn.held_out         <= 1'b0;
        end else begin
            state                <= state_d;
            cnt                  <= cnt_d;
            prev                 <= btn.clean_in;
            btn.press_out        <= press_d;
            btn.release_out      <= release_d;
            btn.click_out        <= click_d;
            btn.double_click_out <= dbl_d;
            btn.long_press_out   <= long_d;
            btn.held_out         <= held_d;
        end
    end

endmodule

// File: tb/tb_button_gesture.sv
// Bench for button_gesture with LONG_MAX=6 and DC_MAX=4.
// Expected output vectors are queued per driven cycle and popped after the edge.
module tb_button_gesture;

    // Output vector bits: {press, release, click, dbl, long, held}
    localparam logic [5:0] Z = 6'b000000;
    localparam logic [5:0] P = 6'b100000;
    localparam logic [5:0] R = 6'b010000;
    localparam logic [5:0] C = 6'b001000;
    localparam logic [5:0] D = 6'b000100;
    localparam logic [5:0] L = 6'b000010;
    localparam logic [5:0] H = 6'b000001;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   idx;
    string scen;
    logic [5:0] exp_q[$];

    button_gesture_if bus();

    button_gesture #(
        .CLK_PERIOD_NS   (1_000_000),
        .LONG_PRESS_MS   (6),
        .DOUBLE_CLICK_MS (4)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .btn    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [5:0] obs,
                         input logic [5:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b (p r c d l h)",
                     tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic lvl,
                       input logic [5:0] exp,
                       input logic r);
        logic [5:0] obs;
        logic [5:0] want;
        @(negedge clk);
        rst          = r;
        bus.clean_in = lvl;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        obs = {bus.press_out, bus.release_out, bus.click_out,
               bus.double_click_out, bus.long_press_out, bus.held_out};
        want = exp_q.pop_front();
        check($sformatf("%s#%0d", scen, idx), obs, want);
        idx++;
    endtask

    task automatic s(input logic lvl, input logic [5:0] exp);
        cyc(lvl, exp, 1'b0);
    endtask

    task automatic sn(input logic lvl, input logic [5:0] exp,
                      input int n);
        for (int i = 0; i < n; i++) cyc(lvl, exp, 1'b0);
    endtask

    task automatic rs(input logic lvl);
        cyc(lvl, Z, 1'b1);
    endtask

    task automatic begin_scen(input string name);
        scen = name;
        idx  = 0;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        bus.clean_in = 1'b0;

        begin_scen("reset");
        rs(0); rs(0);
        sn(0, Z, 2);

        begin_scen("single");
        s(1, P|H); s(1, H); s(0, R);
        sn(0, Z, 3); s(0, C); sn(0, Z, 2);

        begin_scen("double");
        s(1, P|H); s(1, H); s(0, R); s(0, Z);
        s(1, P|H); s(1, H); s(0, R|D);
        sn(0, Z, 6);

        begin_scen("long");
        s(1, P|H); sn(1, H, 5); s(1, L|H); sn(1, H, 3);
        s(0, R); sn(0, Z, 6);

        begin_scen("tie_fall");
        s(1, P|H); sn(1, H, 5); s(0, R);
        sn(0, Z, 3); s(0, C); sn(0, Z, 2);

        begin_scen("tie_rise");
        s(1, P|H); s(1, H); s(0, R); sn(0, Z, 3);
        s(1, P|H); s(1, H); s(0, R|D); sn(0, Z, 6);

        begin_scen("second_long");
        s(1, P|H); s(1, H); s(0, R); s(0, Z);
        s(1, P|H); sn(1, H, 5); s(1, L|H); s(1, H);
        s(0, R); sn(0, Z, 6);

        begin_scen("rst_held");
        rs(1); rs(1);
        sn(1, Z, 3); sn(0, Z, 2);
        s(1, P|H); s(1, H); s(0, R);
        sn(0, Z, 3); s(0, C); s(0, Z);

        begin_scen("rst_wait");
        s(1, P|H); s(1, H); s(0, R); s(0, Z);
        rs(0);
        sn(0, Z, 7);

        begin_scen("rst_pressed");
        s(1, P|H); s(1, H);
        rs(1);
        sn(1, Z, 8); s(0, Z);
        s(1, P|H); s(0, R); sn(0, Z, 3); s(0, C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/button_gesture.md
# button_gesture

Classifies the debounced button level into discrete user gestures: press, release, single click, double click and long press. It sits directly downstream of the debouncer, consuming its clean level. It produces one-cycle event pulses that juggling-control FSMs use to step patterns, toggle modes and reset. All timing windows are parameterised in milliseconds and converted to clock cycles at elaboration.

## Interface

- CLK_PERIOD_NS, default 10: clock period in ns.
- LONG_PRESS_MS, default 500: hold time that qualifies as a long press. LONG_MAX = ceil(LONG_PRESS_MS*1_000_000/CLK_PERIOD_NS) cycles.
- DOUBLE_CLICK_MS, default 250: maximum gap between a release and the second press. DC_MAX = ceil(DOUBLE_CLICK_MS*1_000_000/CLK_PERIOD_NS) cycles.
- Counter width is $clog2(max(LONG_MAX, DC_MAX)+1). LONG_MAX ≥ 2 and DC_MAX ≥ 2 are required.
- clk_in  input  1  system clock; the only clock.
- rst_in  input  1  synchronous, active-high reset.
- clean_in  input  1  debounced button level; 1 = pressed.
- press_out  output  1  one-cycle pulse on every accepted rising edge.
- release_out  output  1  one-cycle pulse on every accepted falling edge.
- click_out  output  1  one-cycle pulse: single short press, confirmed after the double-click window expires.
- double_click_out  output  1  one-cycle pulse: second short press released.
- long_press_out  output  1  one-cycle pulse when a hold reaches LONG_MAX cycles.
- held_out  output  1  level, high while the FSM considers the button down.

## Operation

- An edge register prev tracks clean_in. Rise means clean_in=1 and prev=0. Fall means clean_in=0 and prev=1.
- During reset, prev loads clean_in. If the button is held through reset, no press is reported. The first event after that is a fresh rise.
- States:
  - IDLE: rise → PRESSED, press_out, cnt=0. Fall is ignored; no release_out.
  - PRESSED: cnt increments. Fall → WAIT_SECOND, release_out, cnt=0. If cnt==LONG_MAX-1 with no fall → LONG_HELD, long_press_out.
  - LONG_HELD: fall → IDLE, release_out. No click is ever reported for this press.
  - WAIT_SECOND: cnt increments. Rise → SECOND_PRESSED, press_out, cnt=0. If cnt==DC_MAX-1 with no rise → IDLE, click_out.
  - SECOND_PRESSED: cnt increments. Fall → IDLE, release_out and double_click_out in the same cycle. If cnt==LONG_MAX-1 → LONG_HELD, long_press_out; the first click is discarded.
- Simultaneous events:
  - In PRESSED and SECOND_PRESSED, a fall wins over the long-press threshold in the same cycle.
  - In WAIT_SECOND, a rise wins over the timeout in the same cycle.
- cnt never exceeds max(LONG_MAX, DC_MAX)-1. Every terminal count forces a transition, so no wrap-around is possible.
- held_out = 1 in PRESSED, LONG_HELD and SECOND_PRESSED; 0 otherwise.
- Pulse outputs are mutually exclusive except release_out+double_click_out, which fire together.

## Timing

- Reset values: state=IDLE, cnt=0, all outputs 0.
- All outputs are registered. An edge sampled at clock edge k produces its pulse during cycle k→k+1, i.e. 1 cycle of latency. Each pulse lasts exactly 1 cycle.
- long_press_out: asserted LONG_MAX cycles after the press_out cycle, if clean_in stays 1.
- click_out: asserted DC_MAX cycles after the release_out cycle, if no rise occurs.
- held_out changes in the same cycle as the corresponding press_out/release_out.
- Reset mid-gesture (any state): next cycle is IDLE with all outputs 0 and no pending click. prev resyncs to clean_in.

## Test plan

Bench parameters: CLK_PERIOD_NS=1_000_000, LONG_PRESS_MS=6, DOUBLE_CLICK_MS=4, giving LONG_MAX=6 and DC_MAX=4.

1. Single click: clean_in high 2 cycles, then low. Expect press_out, then release_out 2 cycles later, then click_out 4 cycles after release_out. No other pulses.
2. Double click: high 2, low 2, high 2, low. Expect press, release, press, then release+double_click_out together. No click_out.
3. Long press: high 10 cycles. Expect long_press_out 6 cycles after press_out and held_out high throughout. On the fall, release_out only.
4. Boundary ties:
   - Fall on exactly the cycle cnt==5 in PRESSED → short press, no long_press_out.
   - Rise on exactly the cycle cnt==3 in WAIT_SECOND → SECOND_PRESSED, no click_out.
5. Reset while clean_in=1, then release reset. Expect no press_out. The later fall produces no release_out. The next rise produces press_out.
6. Reset asserted during WAIT_SECOND. Expect no click_out afterwards and all outputs 0 the cycle after reset.
